exam_op_arbiter: RTL

//  Shares one operand/result compute channel (a/b operands in, r result out, e.g. PIO-exported

---
 rtl/exam_op_arbiter_if.sv | 40 ++++
 rtl/exam_op_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/exam_op_arbiter_if.sv
// Bus bundle between the operand/result arbiter and its surroundings.
//   Requester side : req_valid/req_ready/req_a/req_b (N_REQ lanes, flat W-bit slices)
//                    resp_valid/resp_ready (one-hot), resp_r/resp_err (shared)
//   Status         : grant_id (current/last grant), busy
//   Compute side   : op_a/op_b/op_start out, op_done/op_r in
// slave  = arbiter view, master = requesters + compute channel view.
interface exam_op_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 32
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [N_REQ*W-1:0] req_a;
   logic [N_REQ*W-1:0] req_b;
   logic [N_REQ-1:0]   resp_valid;
   logic [N_REQ-1:0]   resp_ready;
   logic [W-1:0]       resp_r;
   logic               resp_err;
   logic [GW-1:0]      grant_id;
   logic               busy;
   logic [W-1:0]       op_a;
   logic [W-1:0]       op_b;
   logic               op_start;
   logic               op_done;
   logic [W-1:0]       op_r;

   modport slave (
      input  req_valid, req_a, req_b, resp_ready, op_done, op_r,
      output req_ready, resp_valid, resp_r, resp_err, grant_id, busy,
             op_a, op_b, op_start
   );

   modport master (
      output req_valid, req_a, req_b, resp_ready, op_done, op_r,
      input  req_ready, resp_valid, resp_r, resp_err, grant_id, busy,
             op_a, op_b, op_start
   );
endinterface

// File: rtl/exam_op_arbiter.sv
// Round-robin arbiter sharing one operand/result compute channel among N_REQ
// requesters. Accepts one request, pulses op_start with registered operands,
// waits for op_done (or gives up after TIMEOUT cycles with an error response),
// then holds a one-hot response until the granted requester takes it.
// Ports:
//   clk    : clock, all logic on posedge
//   rst_in : asynchronous reset, active low
//   bus    : exam_op_arbiter_if.slave (request/response, status, compute channel)
module exam_op_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  rst_in,
   exam_op_arbiter_if.slave      bus
);
   localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [GW-1:0]   rr_q, grant_q;
   logic [W-1:0]    op_a_q, op_b_q, resp_r_q;
   logic            resp_err_q;
   logic [TW-1:0]   timer_q;

   logic            found;
   logic [GW-1:0]   gsel;
   logic            tmo;
   logic [N_REQ-1:0] one;

   assign one = {{(N_REQ-1){1'b0}}, 1'b1};
   assign tmo = (timer_q == TW'(TIMEOUT-1));

   // Scan starting at rr_q so the requester after the last grant has priority.
   always_comb begin
      int idx;
      found = 1'b0;
      gsel  = '0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            gsel  = GW'(idx);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (found) state_d = ISSUE;
         ISSUE: state_d = WAIT;
         WAIT:  if (bus.op_done || tmo) state_d = RESP;
         RESP:  if (bus.resp_ready[grant_q]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.op_start   = 1'b0;
      bus.busy       = (state_q != IDLE);
      case (state_q)
         IDLE:  if (found) bus.req_ready = one << gsel;
         ISSUE: bus.op_start = 1'b1;
         RESP:  bus.resp_valid = one << grant_q;
         default: ;
      endcase
   end

   assign bus.grant_id = grant_q;
   assign bus.op_a     = op_a_q;
   assign bus.op_b     = op_b_q;
   assign bus.resp_r   = resp_r_q;
   assign bus.resp_err = resp_err_q;

   // Datapath registers
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         rr_q       <= '0;
         grant_q    <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         resp_r_q   <= '0;
         resp_err_q <= 1'b0;
         timer_q    <= '0;
      end else begin
         case (state_q)
            IDLE: if (found) begin
               grant_q <= gsel;
               op_a_q  <= bus.req_a[int'(gsel)*W +: W];
               op_b_q  <= bus.req_b[int'(gsel)*W +: W];
            end
            ISSUE: timer_q <= '0;
            WAIT: begin
               // op_done takes precedence over a timeout in the same cycle
               if (bus.op_done) begin
                  resp_r_q   <= bus.op_r;
                  resp_err_q <= 1'b0;
               end else if (tmo) begin
                  resp_r_q   <= '0;
                  resp_err_q <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            RESP: if (bus.resp_ready[grant_q]) begin
               rr_q <= (grant_q == GW'(N_REQ-1)) ? '0 : grant_q + GW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule
